sddr_init_seq: RTL and testbench
================================

// Module: sddr_init_seq
// PURPOSE
//  Hardware DDR3 power-up sequencer; sits directly upstream of the DDR controller's ctrl_cmd register port.
//  On start, it walks the JEDEC init: reset hold, reset release, CKE on, MR2/MR3/MR1/MR0 loads, ZQCL.
//  It issues each step as register writes (reset_state 0x0000, override cmd 0x0004, override addr 0x0008).
//  While idle/done, CPU register traffic passes through unchanged; while busy, the sequencer owns the port.
// PARAMETERS
//  WAIT_BITS     17      width of the shared wait down-counter
//  T_RESET_CYC   20000   cycles RESET# held low (200us @100MHz)
//  T_CKE_CYC     50000   cycles from RESET# release to CKE high (500us)
//  T_XPR_CYC     27      cycles from CKE high to first MRS
//  T_MRD_CYC     4       cycles between consecutive MRS/ZQCL commands
//  T_ZQINIT_CYC  512     cycles after ZQCL before done
//  MR0..MR3      16'h0520,16'h0004,16'h0000,16'h0000   A[15:0] payloads; bank = MR index
//  ODT_EN_FINAL  1'b0    value written to reset_state[4] at finish
// PORTS
//  cpu_clock_i        in   1   single clock
//  reset_i            in   1   async, active-high
//  start_i            in   1   level/pulse; sampled in IDLE or DONE
//  busy_o             out  1   high from start acceptance until DONE
//  done_o             out  1   high in DONE, cleared by reset or restart
//  cpu_cmd_valid_i    in   1   CPU-side ctrl request
//  cpu_cmd_address_i  in   16
//  cpu_cmd_data_i     in   32
//  cpu_cmd_write_i    in   1
//  cpu_cmd_ack_o      out  1   = ctrl_cmd_ack_i when not busy, else 0
//  ctrl_cmd_valid_o   out  1   to controller
//  ctrl_cmd_address_o out  16
//  ctrl_cmd_data_o    out  32
//  ctrl_cmd_write_o   out  1
//  ctrl_cmd_ack_i     in   1   from controller
// BEHAVIOUR
//  Reset: state IDLE; busy_o=0, done_o=0; sequencer bus regs valid=0, addr=0, data=0, write=0; timer=0.
//  Bus write: valid=1, write=1; it is held, with address/data stable, until ack is sampled high at a rising edge.
//    The write completes on that edge and the next state is entered on the same edge.
//  Output mux: busy_o ? sequencer regs : CPU inputs. Purely combinational, with no added latency.
//  States and actions:
//    IDLE/DONE -start_i->  RST_LO   write 0x0000 <= 32'h00 (all reset/cke low, override mode)
//    RST_LO   -> WAIT_RST   load timer T_RESET_CYC
//    WAIT_RST -> RST_HI     write 0x0000 <= 32'h03
//    RST_HI   -> WAIT_CKE   load timer T_CKE_CYC
//    WAIT_CKE -> CKE_ON     write 0x0000 <= 32'h23
//    CKE_ON   -> WAIT_XPR   load timer T_XPR_CYC
//    WAIT_XPR -> MRS_ADDR   write 0x0008 <= {BA[2:0], 13'b0, MRx}; order MR2, MR3, MR1, MR0
//    MRS_ADDR -> MRS_CMD    write 0x0004 <= 4'b0000 (MRS: CS,RAS,CAS,WE low)
//    MRS_CMD  -> WAIT_MRD   load timer T_MRD_CYC; index++; if 4 loads are done -> ZQ_ADDR, else -> MRS_ADDR
//    ZQ_ADDR  -> ZQ_CMD     write 0x0008 <= 32'h400 (A10=1); then write 0x0004 <= 4'b0110
//    ZQ_CMD   -> WAIT_ZQ    load timer T_ZQINIT_CYC
//    WAIT_ZQ  -> FINISH     write 0x0000 <= 32'h2B | ODT_EN_FINAL<<4 (bypass off, CKE on)
//    FINISH   -> DONE       busy_o=0, done_o=1
//  Timer: a load of N gives exactly N cycles in WAIT_*, decrementing to 0; a load of 0 gives a 1-cycle wait.
//    Loads are truncated to WAIT_BITS.
//  start_i while busy: ignored. start_i in DONE: full re-init; done_o drops on the acceptance edge.
//  CPU valid while busy: no ack, and the request never reaches the controller. The CPU must retry after done.
//  Reset mid-sequence: immediate return to IDLE with bus valid low. The controller keeps the last reset_state written.
// CONFIGURATION
//  SDDR_INIT_ZQCL_EN defined: ZQ_ADDR/ZQ_CMD/WAIT_ZQ are present, as above.
//  SDDR_INIT_ZQCL_EN undefined: the states are removed; after the last WAIT_MRD the sequencer goes straight to FINISH.
//    T_ZQINIT_CYC is then unused.
// STRUCTURE
//  Package sddr_pkg contains:
//    register addresses SDDR_REG_RESET/CMD/ADDR;
//    cmd encodings SDDR_CMD_MRS=4'b0000, SDDR_CMD_ZQCL=4'b0110, SDDR_CMD_NOP=4'b0111;
//    reset_state bit indices;
//    typedef enum init_state_t.
//  Sub-module sddr_wait_timer: loadable WAIT_BITS down-counter with load/value/expired outputs.
// TESTING (timing params overridden: T_RESET=5, T_CKE=7, T_XPR=3, T_MRD=2, T_ZQINIT=4)
//  1. Reset, pulse start_i, ack tied 1 -> exact write sequence:
//     0x0000=00, 0x0000=03, 0x0000=23, 4x(0x0008 MR, 0x0004=0), 0x0008=400, 0x0004=6, 0x0000=2B.
//     Then done_o=1. Check gaps of 5, 7, 3, 2 and 4 cycles.
//  2. ack held low for 3 cycles on the MR1 addr write -> valid/addr/data stable for 4 cycles; no skipped step.
//  3. CPU write 0x0008 while busy -> cpu_cmd_ack_o=0 and no controller write.
//     The same CPU write after done -> forwarded in the same cycle with ack=1.
//  4. Assert reset_i during WAIT_CKE -> valid=0 and busy_o=0 asynchronously; a later start_i gives a full sequence from 0x0000=00.
//  5. start_i in DONE -> done_o falls and the sequence repeats. start_i pulses mid-sequence cause no effect.
//  6. Build without SDDR_INIT_ZQCL_EN -> no 0x400/0x6 writes; FINISH follows the MR0 WAIT_MRD.

Source files
------------

// File: rtl/sddr_pkg.sv
// Shared constants, state encoding and helpers for the DDR3 power-up sequencer.
// SDDR_INIT_ZQCL_EN adds the ZQ calibration states to the state set.
package sddr_pkg;

    localparam logic [15:0] SDDR_REG_RESET = 16'h0000;
    localparam logic [15:0] SDDR_REG_CMD   = 16'h0004;
    localparam logic [15:0] SDDR_REG_ADDR  = 16'h0008;

    localparam logic [3:0] SDDR_CMD_MRS  = 4'b0000;
    localparam logic [3:0] SDDR_CMD_ZQCL = 4'b0110;
    localparam logic [3:0] SDDR_CMD_NOP  = 4'b0111;

    localparam int SDDR_RST_RESETN_BIT     = 0;
    localparam int SDDR_RST_CLK_EN_BIT     = 1;
    localparam int SDDR_RST_BYPASS_OFF_BIT = 3;
    localparam int SDDR_RST_ODT_BIT        = 4;
    localparam int SDDR_RST_CKE_BIT        = 5;

    localparam logic [31:0] SDDR_RST_LO_WORD = 32'h0;
    localparam logic [31:0] SDDR_RST_HI_WORD =
        32'((1 << SDDR_RST_RESETN_BIT) | (1 << SDDR_RST_CLK_EN_BIT));
    localparam logic [31:0] SDDR_CKE_WORD =
        SDDR_RST_HI_WORD | 32'(1 << SDDR_RST_CKE_BIT);
    localparam logic [31:0] SDDR_FIN_WORD =
        SDDR_CKE_WORD | 32'(1 << SDDR_RST_BYPASS_OFF_BIT);

    localparam logic [15:0] SDDR_ZQ_ADDR_A10 = 16'h0400;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_RST_LO   = 4'd1,
        ST_WAIT_RST = 4'd2,
        ST_RST_HI   = 4'd3,
        ST_WAIT_CKE = 4'd4,
        ST_CKE_ON   = 4'd5,
        ST_WAIT_XPR = 4'd6,
        ST_MRS_ADDR = 4'd7,
        ST_MRS_CMD  = 4'd8,
        ST_WAIT_MRD = 4'd9,
`ifdef SDDR_INIT_ZQCL_EN
        ST_ZQ_ADDR  = 4'd10,
        ST_ZQ_CMD   = 4'd11,
        ST_WAIT_ZQ  = 4'd12,
`endif
        ST_FINISH   = 4'd13,
        ST_DONE     = 4'd14
    } init_state_t;

    function automatic logic is_write_state(init_state_t s);
        return s inside {ST_RST_LO, ST_RST_HI, ST_CKE_ON,
                         ST_MRS_ADDR, ST_MRS_CMD,
`ifdef SDDR_INIT_ZQCL_EN
                         ST_ZQ_ADDR, ST_ZQ_CMD,
`endif
                         ST_FINISH};
    endfunction

    function automatic logic is_wait_state(init_state_t s);
        return s inside {ST_WAIT_RST, ST_WAIT_CKE,
`ifdef SDDR_INIT_ZQCL_EN
                         ST_WAIT_ZQ,
`endif
                         ST_WAIT_XPR, ST_WAIT_MRD};
    endfunction

    // JEDEC load order is MR2, MR3, MR1, MR0
    function automatic logic [2:0] mr_bank(logic [1:0] idx);
        logic [2:0] ba;
        case (idx)
            2'd0:    ba = 3'd2;
            2'd1:    ba = 3'd3;
            2'd2:    ba = 3'd1;
            default: ba = 3'd0;
        endcase
        return ba;
    endfunction

endpackage

// File: rtl/sddr_init_seq_if.sv
// Register-write bus between a requester and the DDR controller ctrl_cmd port.
// master drives the request, slave returns the ack.
interface sddr_init_seq_if;

    logic        valid;
    logic [15:0] address;
    logic [31:0] data;
    logic        write;
    logic        ack;

    modport master (
        output valid,
        output address,
        output data,
        output write,
        input  ack
    );

    modport slave (
        input  valid,
        input  address,
        input  data,
        input  write,
        output ack
    );

endinterface

// File: rtl/sddr_init_seq_wait_timer.sv
// Loadable down-counter shared by all WAIT_* states of the init sequencer.
// Counts down to zero and holds there until reloaded.
module sddr_wait_timer #(
    parameter int WAIT_BITS = 17
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [WAIT_BITS-1:0] load_val_i,
    output logic [WAIT_BITS-1:0] value_o,
    output logic                 expired_o
);

    logic [WAIT_BITS-1:0] cnt_q;
    logic [WAIT_BITS-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WAIT_BITS'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o   = cnt_q;
    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/sddr_init_seq.sv
// DDR3 power-up sequencer owning the controller register port while busy.
// Define SDDR_INIT_ZQCL_EN to issue ZQCL and wait tZQinit before finishing.
module sddr_init_seq
    import sddr_pkg::*;
#(
    parameter int          WAIT_BITS    = 17,
    parameter int          T_RESET_CYC  = 20000,
    parameter int          T_CKE_CYC    = 50000,
    parameter int          T_XPR_CYC    = 27,
    parameter int          T_MRD_CYC    = 4,
    parameter int          T_ZQINIT_CYC = 512,
    parameter logic [15:0] MR0          = 16'h0520,
    parameter logic [15:0] MR1          = 16'h0004,
    parameter logic [15:0] MR2          = 16'h0000,
    parameter logic [15:0] MR3          = 16'h0000,
    parameter logic        ODT_EN_FINAL = 1'b0
) (
    input  logic           cpu_clock_i,
    input  logic           reset_i,
    input  logic           start_i,
    output logic           busy_o,
    output logic           done_o,
    sddr_init_seq_if.slave  cpu_cmd,
    sddr_init_seq_if.master ctrl_cmd
);

    localparam logic [31:0] FIN_WORD =
        SDDR_FIN_WORD | (32'(ODT_EN_FINAL) << SDDR_RST_ODT_BIT);

    init_state_t state_q, state_d;
    logic [2:0]  mr_cnt_q, mr_cnt_d;
    logic        seq_valid_q, seq_valid_d;
    logic        seq_write_q, seq_write_d;
    logic [15:0] seq_addr_q, seq_addr_d;
    logic [31:0] seq_data_q, seq_data_d;

    logic                 tmr_load;
    logic [WAIT_BITS-1:0] tmr_val;
    logic [WAIT_BITS-1:0] tmr_value;
    logic                 tmr_expired;
    logic                 wait_done;
    logic                 ack;

    function automatic logic [31:0] mrs_word(logic [1:0] idx);
        logic [2:0]  ba;
        logic [15:0] mr;
        ba = mr_bank(idx);
        case (ba)
            3'd0:    mr = MR0;
            3'd1:    mr = MR1;
            3'd2:    mr = MR2;
            default: mr = MR3;
        endcase
        return {ba, 13'b0, mr};
    endfunction

    assign ack       = ctrl_cmd.ack;
    assign wait_done = tmr_expired | (tmr_value == WAIT_BITS'(1));

    always_comb begin
        state_d  = state_q;
        mr_cnt_d = mr_cnt_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d  = ST_RST_LO;
                    mr_cnt_d = 3'd0;
                end
            end
            ST_RST_LO:   if (ack) state_d = ST_WAIT_RST;
            ST_WAIT_RST: if (wait_done) state_d = ST_RST_HI;
            ST_RST_HI:   if (ack) state_d = ST_WAIT_CKE;
            ST_WAIT_CKE: if (wait_done) state_d = ST_CKE_ON;
            ST_CKE_ON:   if (ack) state_d = ST_WAIT_XPR;
            ST_WAIT_XPR: if (wait_done) state_d = ST_MRS_ADDR;
            ST_MRS_ADDR: if (ack) state_d = ST_MRS_CMD;
            ST_MRS_CMD: begin
                if (ack) begin
                    state_d  = ST_WAIT_MRD;
                    mr_cnt_d = mr_cnt_q + 3'd1;
                end
            end
            ST_WAIT_MRD: begin
                if (wait_done) begin
                    if (mr_cnt_q == 3'd4) begin
`ifdef SDDR_INIT_ZQCL_EN
                        state_d = ST_ZQ_ADDR;
`else
                        state_d = ST_FINISH;
`endif
                    end else begin
                        state_d = ST_MRS_ADDR;
                    end
                end
            end
`ifdef SDDR_INIT_ZQCL_EN
            ST_ZQ_ADDR:  if (ack) state_d = ST_ZQ_CMD;
            ST_ZQ_CMD:   if (ack) state_d = ST_WAIT_ZQ;
            ST_WAIT_ZQ:  if (wait_done) state_d = ST_FINISH;
`endif
            ST_FINISH:   if (ack) state_d = ST_DONE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Bus registers follow the state being entered, so a write is on the
    // port for the whole time its state is held.
    always_comb begin
        seq_valid_d = is_write_state(state_d);
        seq_write_d = is_write_state(state_d);
        seq_addr_d  = seq_addr_q;
        seq_data_d  = seq_data_q;
        case (state_d)
            ST_RST_LO: begin
                seq_addr_d = SDDR_REG_RESET;
                seq_data_d = SDDR_RST_LO_WORD;
            end
            ST_RST_HI: begin
                seq_addr_d = SDDR_REG_RESET;
                seq_data_d = SDDR_RST_HI_WORD;
            end
            ST_CKE_ON: begin
                seq_addr_d = SDDR_REG_RESET;
                seq_data_d = SDDR_CKE_WORD;
            end
            ST_MRS_ADDR: begin
                seq_addr_d = SDDR_REG_ADDR;
                seq_data_d = mrs_word(mr_cnt_q[1:0]);
            end
            ST_MRS_CMD: begin
                seq_addr_d = SDDR_REG_CMD;
                seq_data_d = {28'b0, SDDR_CMD_MRS};
            end
`ifdef SDDR_INIT_ZQCL_EN
            ST_ZQ_ADDR: begin
                seq_addr_d = SDDR_REG_ADDR;
                seq_data_d = {16'b0, SDDR_ZQ_ADDR_A10};
            end
            ST_ZQ_CMD: begin
                seq_addr_d = SDDR_REG_CMD;
                seq_data_d = {28'b0, SDDR_CMD_ZQCL};
            end
`endif
            ST_FINISH: begin
                seq_addr_d = SDDR_REG_RESET;
                seq_data_d = FIN_WORD;
            end
            default: ;
        endcase
    end

    assign tmr_load = (state_d != state_q) && is_wait_state(state_d);

    always_comb begin
        case (state_d)
            ST_WAIT_RST: tmr_val = WAIT_BITS'(T_RESET_CYC);
            ST_WAIT_CKE: tmr_val = WAIT_BITS'(T_CKE_CYC);
            ST_WAIT_XPR: tmr_val = WAIT_BITS'(T_XPR_CYC);
            ST_WAIT_MRD: tmr_val = WAIT_BITS'(T_MRD_CYC);
            default:     tmr_val = WAIT_BITS'(T_ZQINIT_CYC);
        endcase
    end

    sddr_wait_timer #(
        .WAIT_BITS (WAIT_BITS)
    ) u_timer (
        .clk_i      (cpu_clock_i),
        .rst_i      (reset_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .value_o    (tmr_value),
        .expired_o  (tmr_expired)
    );

    always_ff @(posedge cpu_clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            mr_cnt_q    <= 3'd0;
            seq_valid_q <= 1'b0;
            seq_write_q <= 1'b0;
            seq_addr_q  <= 16'h0;
            seq_data_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            mr_cnt_q    <= mr_cnt_d;
            seq_valid_q <= seq_valid_d;
            seq_write_q <= seq_write_d;
            seq_addr_q  <= seq_addr_d;
            seq_data_q  <= seq_data_d;
        end
    end

    assign busy_o = !(state_q inside {ST_IDLE, ST_DONE});
    assign done_o = (state_q == ST_DONE);

    assign ctrl_cmd.valid   = busy_o ? seq_valid_q : cpu_cmd.valid;
    assign ctrl_cmd.address = busy_o ? seq_addr_q  : cpu_cmd.address;
    assign ctrl_cmd.data    = busy_o ? seq_data_q  : cpu_cmd.data;
    assign ctrl_cmd.write   = busy_o ? seq_write_q : cpu_cmd.write;
    assign cpu_cmd.ack      = busy_o ? 1'b0 : ctrl_cmd.ack;

endmodule

// File: tb/tb_sddr_init_seq.sv
// Directed bench for sddr_init_seq with shortened timing parameters.
// Honours SDDR_INIT_ZQCL_EN to pick the expected write list.
module tb_sddr_init_seq;

    localparam int T_RESET = 5;
    localparam int T_CKE   = 7;
    localparam int T_XPR   = 3;
    localparam int T_MRD   = 2;
    localparam int T_ZQ    = 4;
`ifdef SDDR_INIT_ZQCL_EN
    localparam int EXP_ZQ  = 1;
`else
    localparam int EXP_ZQ  = 0;
`endif
    localparam logic [31:0] CPU_DATA = 32'hCAFE_0008;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    sddr_init_seq_if cpu_if ();
    sddr_init_seq_if ctrl_if ();

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [15:0] la[$];
    logic [31:0] ld[$];
    int          lc[$];

    logic [15:0] ea[16];
    logic [31:0] ed[16];
    int          eg[16];
    int          n_exp = 0;

    sddr_init_seq #(
        .T_RESET_CYC  (T_RESET),
        .T_CKE_CYC    (T_CKE),
        .T_XPR_CYC    (T_XPR),
        .T_MRD_CYC    (T_MRD),
        .T_ZQINIT_CYC (T_ZQ)
    ) dut (
        .cpu_clock_i (clk),
        .reset_i     (rst),
        .start_i     (start),
        .busy_o      (busy),
        .done_o      (done),
        .cpu_cmd     (cpu_if),
        .ctrl_cmd    (ctrl_if)
    );

    always #5 clk = ~clk;

    // Controller-side log of every completed write and its cycle
    always @(posedge clk) begin
        if (ctrl_if.valid && ctrl_if.write && ctrl_if.ack) begin
            la.push_back(ctrl_if.address);
            ld.push_back(ctrl_if.data);
            lc.push_back(cyc);
        end
        cyc = cyc + 1;
    end

    task automatic add_exp(input logic [15:0] a, input logic [31:0] d,
                           input int g);
        ea[n_exp] = a;
        ed[n_exp] = d;
        eg[n_exp] = g;
        n_exp++;
    endtask

    task automatic build_expected;
        logic [31:0] mrw[4];
        mrw[0] = 32'h4000_0000;
        mrw[1] = 32'h6000_0000;
        mrw[2] = 32'h2000_0004;
        mrw[3] = 32'h0000_0520;
        add_exp(16'h0000, 32'h00, 0);
        add_exp(16'h0000, 32'h03, T_RESET);
        add_exp(16'h0000, 32'h23, T_CKE);
        for (int k = 0; k < 4; k++) begin
            add_exp(16'h0008, mrw[k], (k == 0) ? T_XPR : T_MRD);
            add_exp(16'h0004, 32'h0, 0);
        end
`ifdef SDDR_INIT_ZQCL_EN
        add_exp(16'h0008, 32'h400, T_MRD);
        add_exp(16'h0004, 32'h6, 0);
        add_exp(16'h0000, 32'h2B, T_ZQ);
`else
        add_exp(16'h0000, 32'h2B, T_MRD);
`endif
    endtask

    task automatic clear_log;
        la.delete();
        ld.delete();
        lc.delete();
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        cpu_if.valid   = 1'b0;
        cpu_if.write   = 1'b0;
        cpu_if.address = 16'h0;
        cpu_if.data    = 32'h0;
        ctrl_if.ack    = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got %b want 0", done);
        end
        checks++;
        if (ctrl_if.valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got %b want 0", ctrl_if.valid);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cpu_if.ack !== 1'b1) begin
            failures++;
            $display("FAIL idle_pass got busy=%b ack=%b want 0/1",
                     busy, cpu_if.ack);
        end
    endtask

    task automatic test_full_sequence;
        bit ok;
        clear_log();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL start_accept got busy=%b done=%b want 1/0",
                     busy, done);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL seq_timeout got done=%b want 1", done);
        end
        checks++;
        if (la.size() != n_exp) begin
            failures++;
            $display("FAIL seq_count got %0d want %0d", la.size(), n_exp);
        end
        for (int i = 0; i < n_exp && i < la.size(); i++) begin
            checks++;
            if (la[i] !== ea[i] || ld[i] !== ed[i]) begin
                failures++;
                $display("FAIL seq_write[%0d] got %h=%h want %h=%h",
                         i, la[i], ld[i], ea[i], ed[i]);
            end
            if (i > 0) begin
                checks++;
                if (lc[i] - lc[i-1] - 1 != eg[i]) begin
                    failures++;
                    $display("FAIL seq_gap[%0d] got %0d want %0d",
                             i, lc[i] - lc[i-1] - 1, eg[i]);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL seq_end got done=%b busy=%b want 1/0",
                     done, busy);
        end
    endtask

    task automatic test_ack_stall;
        bit ok;
        bit found;
        clear_log();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ctrl_if.valid && ctrl_if.address == 16'h0008 &&
                ctrl_if.data == 32'h2000_0004) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL stall_find got none want MR1 addr write");
        end
        if (found) begin
            ctrl_if.ack = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                checks++;
                if (ctrl_if.valid !== 1'b1 || ctrl_if.address !== 16'h0008 ||
                    ctrl_if.data !== 32'h2000_0004) begin
                    failures++;
                    $display("FAIL stall_hold[%0d] got %b %h=%h want 1 0008=20000004",
                             k, ctrl_if.valid, ctrl_if.address, ctrl_if.data);
                end
                if (k == 3) ctrl_if.ack = 1'b1;
            end
            @(negedge clk);
            checks++;
            if (ctrl_if.valid !== 1'b1 || ctrl_if.address !== 16'h0004) begin
                failures++;
                $display("FAIL stall_next got %b %h want 1 0004",
                         ctrl_if.valid, ctrl_if.address);
            end
        end
        wait_done(ok);
        checks++;
        if (!ok || la.size() != n_exp) begin
            failures++;
            $display("FAIL stall_count got ok=%b n=%0d want 1 %0d",
                     ok, la.size(), n_exp);
        end
        for (int i = 0; i < n_exp && i < la.size(); i++) begin
            checks++;
            if (la[i] !== ea[i] || ld[i] !== ed[i]) begin
                failures++;
                $display("FAIL stall_write[%0d] got %h=%h want %h=%h",
                         i, la[i], ld[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_cpu_blocked;
        bit ok;
        int hits;
        clear_log();
        pulse_start();
        repeat (8) @(negedge clk);
        cpu_if.valid   = 1'b1;
        cpu_if.write   = 1'b1;
        cpu_if.address = 16'h0008;
        cpu_if.data    = CPU_DATA;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (cpu_if.ack !== 1'b0 || ctrl_if.valid !== 1'b0) begin
                failures++;
                $display("FAIL cpu_block[%0d] got ack=%b valid=%b want 0/0",
                         k, cpu_if.ack, ctrl_if.valid);
            end
        end
        cpu_if.valid = 1'b0;
        wait_done(ok);
        hits = 0;
        foreach (ld[i]) if (ld[i] === CPU_DATA) hits++;
        checks++;
        if (!ok || la.size() != n_exp || hits != 0) begin
            failures++;
            $display("FAIL cpu_leak got ok=%b n=%0d hits=%0d want 1 %0d 0",
                     ok, la.size(), n_exp, hits);
        end
        cpu_if.valid = 1'b1;
        #1;
        checks++;
        if (ctrl_if.valid !== 1'b1 || ctrl_if.address !== 16'h0008 ||
            ctrl_if.data !== CPU_DATA || ctrl_if.write !== 1'b1 ||
            cpu_if.ack !== 1'b1) begin
            failures++;
            $display("FAIL cpu_pass got v=%b %h=%h w=%b ack=%b want 1 0008=%h 1 1",
                     ctrl_if.valid, ctrl_if.address, ctrl_if.data,
                     ctrl_if.write, cpu_if.ack, CPU_DATA);
        end
        @(negedge clk);
        cpu_if.valid = 1'b0;
        cpu_if.write = 1'b0;
        checks++;
        if (ld.size() != n_exp + 1 || ld[ld.size()-1] !== CPU_DATA) begin
            failures++;
            $display("FAIL cpu_fwd got n=%0d want %0d", ld.size(), n_exp + 1);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        clear_log();
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            if (la.size() >= 2) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || la.size() != 2) begin
            failures++;
            $display("FAIL mid_pre got busy=%b n=%0d want 1 2", busy, la.size());
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || ctrl_if.valid !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL mid_async got busy=%b valid=%b done=%b want 0/0/0",
                     busy, ctrl_if.valid, done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || la.size() != 2) begin
            failures++;
            $display("FAIL mid_idle got busy=%b n=%0d want 0 2", busy, la.size());
        end
        clear_log();
        pulse_start();
        wait_done(ok);
        checks++;
        if (!ok || la.size() != n_exp) begin
            failures++;
            $display("FAIL mid_rerun got ok=%b n=%0d want 1 %0d",
                     ok, la.size(), n_exp);
        end
        for (int i = 0; i < n_exp && i < la.size(); i++) begin
            checks++;
            if (la[i] !== ea[i] || ld[i] !== ed[i]) begin
                failures++;
                $display("FAIL mid_write[%0d] got %h=%h want %h=%h",
                         i, la[i], ld[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_pre got done=%b want 1", done);
        end
        clear_log();
        pulse_start();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart got done=%b busy=%b want 0/1",
                     done, busy);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = (i == 4 || i == 13);
        end
        start = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok || la.size() != n_exp) begin
            failures++;
            $display("FAIL b2b_count got ok=%b n=%0d want 1 %0d",
                     ok, la.size(), n_exp);
        end
        for (int i = 0; i < n_exp && i < la.size(); i++) begin
            checks++;
            if (la[i] !== ea[i] || ld[i] !== ed[i]) begin
                failures++;
                $display("FAIL b2b_write[%0d] got %h=%h want %h=%h",
                         i, la[i], ld[i], ea[i], ed[i]);
            end
            if (i > 0) begin
                checks++;
                if (lc[i] - lc[i-1] - 1 != eg[i]) begin
                    failures++;
                    $display("FAIL b2b_gap[%0d] got %0d want %0d",
                             i, lc[i] - lc[i-1] - 1, eg[i]);
                end
            end
        end
    endtask

    task automatic test_zq_config;
        int zq;
        int n;
        zq = 0;
        foreach (ld[i]) if (la[i] === 16'h0008 && ld[i] === 32'h400) zq++;
        checks++;
        if (zq != EXP_ZQ) begin
            failures++;
            $display("FAIL zq_count got %0d want %0d", zq, EXP_ZQ);
        end
        n = la.size();
        if (n >= 3) begin
            checks++;
            if (la[n-1] !== 16'h0000 || ld[n-1] !== 32'h2B) begin
                failures++;
                $display("FAIL zq_last got %h=%h want 0000=2b",
                         la[n-1], ld[n-1]);
            end
            checks++;
            if (ld[n-3] !== ((EXP_ZQ == 1) ? 32'h400 : 32'h520)) begin
                failures++;
                $display("FAIL zq_prev got %h want %h", ld[n-3],
                         (EXP_ZQ == 1) ? 32'h400 : 32'h520);
            end
            checks++;
            if (lc[n-1] - lc[n-2] - 1 != ((EXP_ZQ == 1) ? T_ZQ : T_MRD)) begin
                failures++;
                $display("FAIL zq_gap got %0d want %0d", lc[n-1] - lc[n-2] - 1,
                         (EXP_ZQ == 1) ? T_ZQ : T_MRD);
            end
        end
    endtask

    initial begin
        build_expected();
        test_reset();
        test_full_sequence();
        test_ack_stall();
        test_cpu_blocked();
        test_reset_mid();
        test_back_to_back();
        test_zq_config();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
